// File: rtl/text_console_pkg.sv
// Shared constants for the text console: state encoding, control codes and default geometry.
package text_console_pkg;

    localparam int DEF_COLS = 30;
    localparam int DEF_ROWS = 17;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PUT    = 2'd1;
    localparam logic [1:0] ST_ROWCLR = 2'd2;
    localparam logic [1:0] ST_SCRCLR = 2'd3;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    function automatic logic is_printable(input logic [7:0] c);
        return !(c == CH_BS || c == CH_LF || c == CH_FF || c == CH_CR);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Increment-with-wrap arithmetic for a (row, col) pair bounded by COLS x ROWS.
module text_cursor
    import text_console_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic [4:0] row_i,
    input  logic [4:0] col_i,
    output logic [4:0] row_inc_o,
    output logic [4:0] col_inc_o,
    output logic       row_last_o,
    output logic       col_last_o
);

    assign col_last_o = (col_i == 5'(COLS - 1));
    assign row_last_o = (row_i == 5'(ROWS - 1));
    assign col_inc_o  = col_last_o ? 5'd0 : col_i + 5'd1;
    assign row_inc_o  = row_last_o ? 5'd0 : row_i + 5'd1;

endmodule

// File: rtl/text_console.sv
// Character-cell console: turns a character/control-code stream into VRAM writes,
// tracks the cursor and performs row and full-screen clears.
module text_console
    import text_console_pkg::*;
#(
    parameter int         COLS       = DEF_COLS,
    parameter int         ROWS       = DEF_ROWS,
    parameter logic [7:0] BLANK_ATTR = 8'h07
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  chr_i,
    input  logic [7:0]  attr_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        clear_i,
    output logic        vram_cea_o,
    output logic [9:0]  vram_ada_o,
    output logic [15:0] vram_din_o,
    output logic [4:0]  cursor_row_o,
    output logic [4:0]  cursor_col_o,
    output logic        busy_o
);

    localparam logic [15:0] BLANK = {BLANK_ATTR, CH_SPACE};

    logic [1:0]  state_q, state_d;
    logic        boot_q, boot_d;
    logic        pend_q, pend_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  cnt_row_q, cnt_row_d;
    logic [4:0]  cnt_col_q, cnt_col_d;
    logic [7:0]  chr_q, chr_d;
    logic        cea_q, cea_d;
    logic [9:0]  ada_q, ada_d;
    logic [15:0] din_q, din_d;

    logic        go_idle, go_row, go_scr;
    logic        sel_cursor;
    logic [4:0]  inc_row_in, inc_col_in, inc_row, inc_col;
    logic        row_last, col_last;

    // PUT is the only state that steps the cursor; clears step the counter.
    assign sel_cursor = (state_q == ST_PUT);
    assign inc_row_in = sel_cursor ? row_q : cnt_row_q;
    assign inc_col_in = sel_cursor ? col_q : cnt_col_q;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .row_i      (inc_row_in),
        .col_i      (inc_col_in),
        .row_inc_o  (inc_row),
        .col_inc_o  (inc_col),
        .row_last_o (row_last),
        .col_last_o (col_last)
    );

    always_comb begin
        state_d   = state_q;
        boot_d    = boot_q;
        pend_d    = pend_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_row_d = cnt_row_q;
        cnt_col_d = cnt_col_q;
        chr_d     = chr_q;
        cea_d     = 1'b0;
        ada_d     = ada_q;
        din_d     = din_q;
        go_idle   = 1'b0;
        go_row    = 1'b0;
        go_scr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!boot_q) begin
                    boot_d = 1'b1;
                    go_scr = 1'b1;
                end else if (clear_i || pend_q) begin
                    go_scr = 1'b1;
                end else if (valid_i) begin
                    state_d = ST_PUT;
                    chr_d   = chr_i;
                    if (is_printable(chr_i)) begin
                        cea_d = 1'b1;
                        ada_d = {row_q, col_q};
                        din_d = {attr_i, chr_i};
                    end else if (chr_i == CH_BS && col_q != 5'd0) begin
                        cea_d = 1'b1;
                        ada_d = {row_q, col_q - 5'd1};
                        din_d = BLANK;
                    end
                end
            end
            ST_PUT: begin
                if (is_printable(chr_q)) begin
                    if (col_last) begin
                        col_d  = 5'd0;
                        row_d  = inc_row;
                        go_row = 1'b1;
                    end else begin
                        col_d   = inc_col;
                        go_idle = 1'b1;
                    end
                end else if (chr_q == CH_LF) begin
                    row_d  = inc_row;
                    go_row = 1'b1;
                end else if (chr_q == CH_CR) begin
                    col_d   = 5'd0;
                    go_idle = 1'b1;
                end else if (chr_q == CH_FF) begin
                    go_scr = 1'b1;
                end else begin
                    if (col_q != 5'd0) col_d = col_q - 5'd1;
                    go_idle = 1'b1;
                end
            end
            ST_ROWCLR: begin
                if (col_last) begin
                    go_idle = 1'b1;
                end else begin
                    cnt_col_d = inc_col;
                    cea_d     = 1'b1;
                    ada_d     = {row_q, inc_col};
                    din_d     = BLANK;
                end
            end
            default: begin
                if (col_last && row_last) begin
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                    go_idle = 1'b1;
                end else begin
                    cnt_col_d = inc_col;
                    if (col_last) cnt_row_d = inc_row;
                    cea_d = 1'b1;
                    ada_d = {cnt_row_d, cnt_col_d};
                    din_d = BLANK;
                end
            end
        endcase

        // A clear seen while busy is held and taken instead of the next IDLE.
        if (state_q != ST_IDLE && clear_i) pend_d = 1'b1;

        if (go_idle) begin
            if (pend_d) go_scr = 1'b1;
            else        state_d = ST_IDLE;
        end

        // The first blank of a clear is issued on the entry edge so that
        // every cycle spent in ROWCLR/SCRCLR carries exactly one write.
        if (go_row) begin
            state_d   = ST_ROWCLR;
            cnt_col_d = 5'd0;
            cea_d     = 1'b1;
            ada_d     = {row_d, 5'd0};
            din_d     = BLANK;
        end

        if (go_scr) begin
            state_d   = ST_SCRCLR;
            pend_d    = 1'b0;
            cnt_row_d = 5'd0;
            cnt_col_d = 5'd0;
            cea_d     = 1'b1;
            ada_d     = 10'd0;
            din_d     = BLANK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            boot_q    <= 1'b0;
            pend_q    <= 1'b0;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            cnt_row_q <= 5'd0;
            cnt_col_q <= 5'd0;
            chr_q     <= 8'd0;
            cea_q     <= 1'b0;
            ada_q     <= 10'd0;
            din_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            boot_q    <= boot_d;
            pend_q    <= pend_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_row_q <= cnt_row_d;
            cnt_col_q <= cnt_col_d;
            chr_q     <= chr_d;
            cea_q     <= cea_d;
            ada_q     <= ada_d;
            din_q     <= din_d;
        end
    end

    assign ready_o      = boot_q && (state_q == ST_IDLE) && !clear_i && !pend_q;
    assign busy_o       = (state_q == ST_ROWCLR) || (state_q == ST_SCRCLR);
    assign vram_cea_o   = cea_q;
    assign vram_ada_o   = ada_q;
    assign vram_din_o   = din_q;
    assign cursor_row_o = row_q;
    assign cursor_col_o = col_q;

endmodule
